// File: rtl/g_nred_pkg.sv
// g_nred_pkg: shared definitions for the g_nred family of reduction gates.
//   - MODE encodings for the reduction function select
//   - legal parameter ranges for WIDTH, PIPE and CNTW
package g_nred_pkg;

  localparam logic [1:0] G_MODE_OR  = 2'b00;
  localparam logic [1:0] G_MODE_AND = 2'b01;
  localparam logic [1:0] G_MODE_XOR = 2'b10;
  // 2'b11 is reserved and decodes as OR.

  localparam int G_WIDTH_MIN = 2;
  localparam int G_WIDTH_MAX = 64;
  localparam int G_PIPE_MIN  = 1;
  localparam int G_PIPE_MAX  = 4;
  localparam int G_CNTW_MIN  = 1;
  localparam int G_CNTW_MAX  = 16;

endpackage

// File: rtl/g_nred_fn.sv
// g_nred_fn: combinational WIDTH-bit reduction with selectable function and
// optional output inversion.
//   a     in  WIDTH  reduction inputs
//   mode  in  2      00 OR, 01 AND, 10 XOR, 11 OR
//   inv   in  1      invert the reduction result
//   r     out 1      f(mode, a) ^ inv
import g_nred_pkg::*;

module g_nred_fn #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [1:0]       mode,
  input  logic             inv,
  output logic             r
);

  logic red;

  always_comb begin
    red = |a;
    case (mode)
      G_MODE_OR:  red = |a;
      G_MODE_AND: red = &a;
      G_MODE_XOR: red = ^a;
      default:    red = |a;
    endcase
    r = red ^ inv;
  end

endmodule

// File: rtl/g_nred_reg.sv
// g_nred_reg: registered, pipelined N-input reduction gate used as a
// status/flag collector.
//   CK      in  1      clock, rising edge
//   CDN     in  1      asynchronous active-low reset, clears all registers
//   CE      in  1      clock enable for pipeline stages and Y
//   A       in  WIDTH  reduction inputs
//   MODE    in  2      00 OR, 01 AND, 10 XOR, 11 OR
//   INV     in  1      invert reduction result
//   STKY    in  1      sticky mode, Y latches 1 until CLR
//   CLR     in  1      synchronous clear of sticky state, counter, overflow
//   Y       out 1      registered result (PIPE edges after A)
//   YR      out 1      one-cycle pulse, the cycle after Y rises
//   CNT     out CNTW   saturating count of Y rising edges
//   CNTOVF  out 1      set when an increment hits a saturated CNT
import g_nred_pkg::*;

module g_nred_reg #(
  parameter int WIDTH = 4,
  parameter int PIPE  = 1,
  parameter int CNTW  = 8
) (
  input  logic             CK,
  input  logic             CDN,
  input  logic             CE,
  input  logic [WIDTH-1:0] A,
  input  logic [1:0]       MODE,
  input  logic             INV,
  input  logic             STKY,
  input  logic             CLR,
  output logic             Y,
  output logic             YR,
  output logic [CNTW-1:0]  CNT,
  output logic             CNTOVF
);

  if (WIDTH < G_WIDTH_MIN || WIDTH > G_WIDTH_MAX) begin : g_bad_width
    $error("g_nred_reg: WIDTH out of range");
  end
  if (PIPE < G_PIPE_MIN || PIPE > G_PIPE_MAX) begin : g_bad_pipe
    $error("g_nred_reg: PIPE out of range");
  end
  if (CNTW < G_CNTW_MIN || CNTW > G_CNTW_MAX) begin : g_bad_cntw
    $error("g_nred_reg: CNTW out of range");
  end

  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  logic r;
  logic s;

  g_nred_fn #(.WIDTH(WIDTH)) u_fn (
    .a    (A),
    .mode (MODE),
    .inv  (INV),
    .r    (r)
  );

  // Pipeline p1..p(PIPE-1); the Y register is the final stage.
  if (PIPE == 1) begin : g_no_pipe
    assign s = r;
  end else begin : g_pipe
    logic [PIPE-2:0] pipe_q;
    logic [PIPE-2:0] pipe_d;

    always_comb begin
      pipe_d = pipe_q;
      if (CE) begin
        pipe_d[0] = r;
        for (int k = 1; k < PIPE-1; k++) begin
          pipe_d[k] = pipe_q[k-1];
        end
      end
    end

    always_ff @(posedge CK or negedge CDN) begin
      if (!CDN) pipe_q <= '0;
      else      pipe_q <= pipe_d;
    end

    assign s = pipe_q[PIPE-2];
  end

  logic            y_q, y_d;
  logic            y_dly_q;
  logic            yr_q, yr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            rise;

  always_comb begin
    y_d = y_q;
    if (CE) begin
      // CLR releases the sticky hold; the new value is plain s.
      if (CLR)       y_d = s;
      else if (STKY) y_d = y_q | s;
      else           y_d = s;
    end else if (CLR && STKY) begin
      y_d = 1'b0;
    end
  end

  // Edge detect and counter run every edge regardless of CE.
  assign rise = y_q & ~y_dly_q;

  always_comb begin
    yr_d  = rise;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (CLR) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (rise) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNTW'(1);
      else                  ovf_d = 1'b1;
    end
  end

  always_ff @(posedge CK or negedge CDN) begin
    if (!CDN) begin
      y_q     <= 1'b0;
      y_dly_q <= 1'b0;
      yr_q    <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      y_q     <= y_d;
      y_dly_q <= y_q;
      yr_q    <= yr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Y      = y_q;
  assign YR     = yr_q;
  assign CNT    = cnt_q;
  assign CNTOVF = ovf_q;

endmodule
